flit_credit_rx: RTL and testbench
=================================

// Module: flit_credit_rx
// PURPOSE
//  Receive end of a valid-only flit link: flits arrive with no backpressure.
//  - Buffers incoming flits in a DEPTH-entry FIFO and presents them downstream over a valid/ready handshake.
//  - Returns one credit pulse upstream per freed entry, so the transmitter never overruns the buffer.
//  - Sits at the far end of the link's flit pipeline stages.
// PARAMETERS
//  FLIT_DW  512  flit data width
//  DEPTH    8    FIFO entries = initial credits granted to transmitter (>=2)
// PORTS
//  clk            in   1         single clock, all logic on posedge
//  rst            in   1         asynchronous, active-high reset
//  flit_data_in   in   FLIT_DW   incoming flit data
//  flit_vld_in    in   1         incoming flit valid; flit captured every cycle this is 1
//  out_data       out  FLIT_DW   FIFO head flit
//  out_valid      out  1         FIFO non-empty
//  out_ready      in   1         downstream accept; pop when out_valid & out_ready
//  credit_rtn     out  1         one-cycle pulse = one credit returned upstream
//  init_done      out  1         initial credit grant complete
//  overflow_err   out  1         sticky: flit arrived with FIFO full and no pop
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_valid=0, credit_rtn=0, init_done=0, overflow_err=0.
//   - Pointers and count cleared; pending_cnt=DEPTH; state=INIT.
//   - FIFO storage and out_data are not reset (X until first write).
//  FIFO:
//   - Write when flit_vld_in=1.
//   - Pop when out_valid & out_ready.
//   - Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//   - out_valid = (count!=0); out_data = mem[rd_ptr].
//   - No bypass: flit written at edge N -> out_valid=1 from cycle after edge N.
//   - Write on empty FIFO with out_ready=1: no pop in the write cycle.
//   - Write and pop in the same cycle: count unchanged, both pointers advance.
//   - Write when count==DEPTH and pop same cycle: write accepted, count stays DEPTH.
//   - Write when count==DEPTH and no pop: flit dropped, FIFO unchanged, overflow_err <= 1.
//     overflow_err stays set until rst.
//   - out_ready while out_valid=0: ignored.
//  Credit return:
//   - pending_cnt, width $clog2(DEPTH+1), counts credits owed upstream.
//   - Each cycle:
//     credit_rtn    <= (pending_cnt!=0)
//     pending_cnt   <= pending_cnt - (pending_cnt!=0) + pop
//   - Pop-to-credit latency: 1 cycle when pending_cnt==0; otherwise queued behind owed credits.
//   - At most one credit per cycle. Pop and issue in the same cycle net to zero.
//   - Invariant pending_cnt + count + credits_in_flight <= DEPTH; pending_cnt never exceeds DEPTH.
//  FSM:
//   - INIT: post-reset grant of DEPTH credits, issued via pending_cnt.
//     Transitions to RUN at the first edge where pending_cnt==0.
//     Pops during INIT are legal; they simply extend the grant.
//   - RUN: steady state; init_done=1 (registered, 1 in RUN only).
//   - RUN->INIT only via rst.
//  Reset mid-operation:
//   - All buffered flits and owed credits are discarded.
//   - Re-enters INIT and re-grants DEPTH credits.
//   - The transmitter is reset together with this block.
// CONFIGURATION
//  FLIT_RX_OCC_EN defined:
//   - Adds output port occupancy [$clog2(DEPTH+1)-1:0] = registered count (reset 0).
//   - Adds output port occ_hwm, same width: sticky high-water mark of count (reset 0).
//  FLIT_RX_OCC_EN undefined:
//   - Neither port exists; no extra logic. All other behaviour identical.
// TESTING
//  - Reset release, no traffic, DEPTH=8 -> credit_rtn=1 for exactly 8 consecutive cycles,
//    starting 1 cycle after release. init_done=1 on the cycle after the last credit.
//  - 3 flits A,B,C back-to-back, out_ready=0 -> out_valid rises 1 cycle after A.
//    Raise out_ready -> A,B,C in order; exactly 3 credit_rtn pulses, each 1 cycle after its pop.
//  - Fill 8 flits, out_ready=0, then 9th flit with no pop -> 9th dropped, overflow_err=1 and stays 1.
//    Drain -> only the first 8 flits emerge.
//  - FIFO full, 9th flit arrives together with a pop -> 9th accepted, overflow_err stays 0, count=8.
//  - Continuous flit_vld_in=1 with out_ready=1 after INIT -> 1 flit/cycle out, 1 credit/cycle,
//    credits never exceed 8 outstanding.
//  - Assert rst with 5 flits buffered and 2 credits owed -> out_valid=0 immediately;
//    after release, exactly 8 credits, no stale flits.

Source files
------------

// File: rtl/flit_credit_rx.sv
// flit_credit_rx: receive end of a valid-only (no backpressure) flit link.
//   Buffers flits in a DEPTH-entry FIFO, presents them over valid/ready, and
//   returns one credit pulse upstream per freed entry (DEPTH credits granted after reset).
// Latency: flit written at edge N is visible on out_valid/out_data after edge N (no bypass);
//   a pop is credited 1 cycle later when no credits are owed, otherwise queued behind them.
// Backpressure: none upstream (credit-based); out_ready stalls the head, and a flit arriving
//   while full with no pop is dropped and latches overflow_err until rst.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   flit_data_in/flit_vld_in  incoming flit, captured every cycle valid is 1
//   out_data/out_valid        FIFO head / FIFO non-empty
//   out_ready                 downstream accept
//   credit_rtn                one-cycle pulse per credit returned upstream
//   init_done                 initial DEPTH-credit grant has completed
//   overflow_err              sticky overflow flag
// Optional: define FLIT_RX_OCC_EN to add occupancy (current count) and
//   occ_hwm (sticky high-water mark of count) outputs.
module flit_credit_rx #(
  parameter int FLIT_DW = 512,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLIT_DW-1:0] flit_data_in,
  input  logic               flit_vld_in,
  output logic [FLIT_DW-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               credit_rtn,
  output logic               init_done,
  output logic               overflow_err
`ifdef FLIT_RX_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] occ_hwm
`endif
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [FLIT_DW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          credit_q;
  logic          ovf_q, ovf_d;
  logic          full, pop, wr_en, pend_nz;
  state_t        state_q;
  logic          init_done_q;

  always_comb begin
    full     = (count_q == FULL);
    pop      = (count_q != '0) & out_ready;
    // A full FIFO still takes a flit when the head leaves in the same cycle.
    wr_en    = flit_vld_in & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    ovf_d    = ovf_q | (flit_vld_in & full & ~pop);
    // Issue one owed credit per cycle; each pop adds one owed credit.
    pend_nz  = (pend_q != '0);
    pend_d   = pend_q - CW'(pend_nz) + CW'(pop);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= flit_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= FULL;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      credit_q <= pend_nz;
      ovf_q    <= ovf_d;
    end
  end

  // INIT drains the post-reset grant held in pend_q; pops during INIT just extend it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!pend_nz) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_data     = mem[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign credit_rtn   = credit_q;
  assign init_done    = init_done_q;
  assign overflow_err = ovf_q;

`ifdef FLIT_RX_OCC_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end
  end

  assign occupancy = count_q;
  assign occ_hwm   = hwm_q;
`endif

endmodule

// File: tb/tb_flit_credit_rx.sv
// tb_flit_credit_rx: self-checking bench for flit_credit_rx (FLIT_DW=512, DEPTH=8).
//   Directed vector table, hand-written reset/overflow/full-pop sequences, and a
//   credit-respecting random transmitter checked against a queue-based reference model.
module tb_flit_credit_rx;

  localparam int FLIT_DW = 512;
  localparam int DEPTH   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [FLIT_DW-1:0] flit_data_in = '0;
  logic               flit_vld_in = 1'b0;
  logic [FLIT_DW-1:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               credit_rtn;
  logic               init_done;
  logic               overflow_err;
`ifdef FLIT_RX_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic [$clog2(DEPTH+1)-1:0] occ_hwm;
`endif

  flit_credit_rx #(.FLIT_DW(FLIT_DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_data_in (flit_data_in),
    .flit_vld_in  (flit_vld_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .credit_rtn   (credit_rtn),
    .init_done    (init_done),
    .overflow_err (overflow_err)
`ifdef FLIT_RX_OCC_EN
    ,
    .occupancy    (occupancy),
    .occ_hwm      (occ_hwm)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: buffered flits as a queue, owed credits as an integer.
  logic [FLIT_DW-1:0] mq[$];
  int                 m_pend;
  logic               m_credit;
  logic               m_init;
  logic               m_ovf;
  int                 tx_cred;

  typedef struct {
    logic        vld;
    logic [15:0] dat;
    logic        rdy;
    logic        e_valid;
    logic        e_dchk;
    logic [15:0] e_dat;
    logic        e_credit;
    logic        e_init;
    logic        e_ovf;
  } vec_t;

  vec_t vec[28];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic ev, input logic edc, input logic [15:0] ed,
                              input logic ec, input logic ei, input logic eo);
    vec_t t;
    t.vld = v; t.dat = d; t.rdy = r;
    t.e_valid = ev; t.e_dchk = edc; t.e_dat = ed;
    t.e_credit = ec; t.e_init = ei; t.e_ovf = eo;
    return t;
  endfunction

  function automatic logic [FLIT_DW-1:0] rand_flit();
    logic [FLIT_DW-1:0] f;
    for (int k = 0; k < FLIT_DW / 32; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [FLIT_DW-1:0] act, input logic [FLIT_DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend   = DEPTH;
    m_credit = 1'b0;
    m_init   = 1'b0;
    m_ovf    = 1'b0;
    tx_cred  = 0;
  endtask

  task automatic model_step(input logic v, input logic [FLIT_DW-1:0] d, input logic r);
    logic pop;
    logic cr;
    pop = (mq.size() != 0) && r;
    cr  = (m_pend != 0);
    if (m_pend == 0) m_init = 1'b1;
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    m_pend   = m_pend - (cr ? 1 : 0) + (pop ? 1 : 0);
    m_credit = cr;
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic tick(input logic v, input logic [FLIT_DW-1:0] d, input logic r);
    flit_vld_in  = v;
    flit_data_in = d;
    out_ready    = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chkd("out_data", out_data, mq[0]);
    chk("credit_rtn", credit_rtn, m_credit);
    chk("init_done", init_done, m_init);
    chk("overflow_err", overflow_err, m_ovf);
    if (credit_rtn === 1'b1) tx_cred++;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    flit_vld_in  = 1'b0;
    out_ready    = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_credit_rtn", credit_rtn, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_overflow_err", overflow_err, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Idle after reset release: exactly DEPTH consecutive credits from cycle 1, init_done next.
  task automatic init_seq();
    int n = 0;
    int first = -1;
    int last = -1;
    int idone = -1;
    for (int c = 1; c <= DEPTH + 4; c++) begin
      tick(1'b0, '0, 1'b0);
      if (credit_rtn === 1'b1) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
      if (init_done === 1'b1 && idone < 0) idone = c;
    end
    chk_int("init_credit_count", n, DEPTH);
    chk_int("init_first_credit", first, 1);
    chk_int("init_last_credit", last, DEPTH);
    chk_int("init_done_cycle", idone, DEPTH + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cr;
    int n_v;
    logic v;
    logic r;

    // Vectors assume start in RUN, empty, no owed credits.
    vec[0] = mk(1, 16'h01, 0, 1, 1, 16'h01, 0, 1, 0);
    vec[1] = mk(1, 16'h02, 0, 1, 1, 16'h01, 0, 1, 0);
    vec[2] = mk(1, 16'h03, 0, 1, 1, 16'h01, 0, 1, 0);
    vec[3] = mk(0, 16'h00, 1, 1, 1, 16'h02, 0, 1, 0);
    vec[4] = mk(0, 16'h00, 1, 1, 1, 16'h03, 1, 1, 0);
    vec[5] = mk(0, 16'h00, 1, 0, 0, 16'h00, 1, 1, 0);
    vec[6] = mk(0, 16'h00, 0, 0, 0, 16'h00, 1, 1, 0);
    vec[7] = mk(0, 16'h00, 0, 0, 0, 16'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      vec[8+i] = mk(1, 16'h10 + 16'(i), 0, 1, 1, 16'h10, 0, 1, 0);
    vec[16] = mk(1, 16'h99, 0, 1, 1, 16'h10, 0, 1, 1);
    vec[17] = mk(0, 16'h00, 0, 1, 1, 16'h10, 0, 1, 1);
    for (int i = 0; i < 8; i++)
      vec[18+i] = mk(0, 16'h00, 1, i < 7, i < 7, 16'h11 + 16'(i), i != 0, 1, 1);
    vec[26] = mk(0, 16'h00, 0, 0, 0, 16'h00, 1, 1, 1);
    vec[27] = mk(0, 16'h00, 0, 0, 0, 16'h00, 0, 1, 1);

    // Reset and initial credit grant.
    do_reset();
    init_seq();

    // Table: ordering/latency of 3 flits, then overflow and drain of 8.
    for (int i = 0; i < 28; i++) begin
      tick(vec[i].vld, FLIT_DW'(vec[i].dat), vec[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, vec[i].e_valid);
      if (vec[i].e_dchk) chkd($sformatf("tbl%0d_data", i), out_data, FLIT_DW'(vec[i].e_dat));
      chk($sformatf("tbl%0d_credit", i), credit_rtn, vec[i].e_credit);
      chk($sformatf("tbl%0d_init", i), init_done, vec[i].e_init);
      chk($sformatf("tbl%0d_ovf", i), overflow_err, vec[i].e_ovf);
    end

    // Full FIFO, extra flit arrives together with a pop: accepted, no error.
    do_reset();
    init_seq();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, FLIT_DW'(32'h20 + i), 1'b0);
    tick(1'b1, FLIT_DW'(32'hAA), 1'b1);
    chk("fullpop_ovf", overflow_err, 1'b0);
    chk("fullpop_valid", out_valid, 1'b1);
    chkd("fullpop_head", out_data, FLIT_DW'(32'h21));
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, '0, 1'b1);
      if (i == DEPTH - 2) chkd("fullpop_last", out_data, FLIT_DW'(32'hAA));
    end
    chk("fullpop_drained", out_valid, 1'b0);
    chk("fullpop_ovf_end", overflow_err, 1'b0);

    // Continuous traffic with a credit-respecting transmitter.
    do_reset();
    n_cr = 0;
    n_v  = 0;
    for (int c = 0; c < 60; c++) begin
      v = (tx_cred > 0);
      if (v) tx_cred--;
      tick(v, rand_flit(), 1'b1);
      if (c >= 20) begin
        if (credit_rtn === 1'b1) n_cr++;
        if (out_valid === 1'b1) n_v++;
      end
      chk("cont_outstanding", (tx_cred + mq.size()) <= DEPTH, 1'b1);
    end
    chk_int("cont_credits", n_cr, 40);
    chk_int("cont_valid", n_v, 40);

    // Random traffic and random downstream stalls.
    for (int c = 0; c < 1500; c++) begin
      v = (tx_cred > 0) && ($urandom_range(3) != 0);
      r = ($urandom_range(2) != 0);
      if (v) tx_cred--;
      tick(v, rand_flit(), r);
      chk("rand_outstanding", (tx_cred + mq.size()) <= DEPTH, 1'b1);
    end

    // Reset mid-operation: 5 flits buffered, 2 credits owed.
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, rand_flit(), 1'b0);
    tick(1'b0, '0, 1'b1);
    chk_int("mid_buffered", mq.size(), 5);
    chk("mid_valid_before", out_valid, 1'b1);
    do_reset();
    init_seq();
    chk("mid_no_stale", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
